keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Input-side front end for the multiplier board. Scans a 4x4 hex keypad matrix and debounces key presses.
- Delivers one 4-bit key code per press over a valid/ready handshake. Downstream logic uses these codes to build the a/b operands and issue load.
- Uses the same scan-tick cadence as the seven-segment refresh logic.

Parameters:
- SCAN_DIV, 25000, clk cycles per row-scan tick; must be >= 2.
- DEBOUNCE_SCANS, 4, consecutive matching samples needed to confirm a press or a release; must be >= 1.

Ports:
- clk  input  1  system clock; all flops clocked on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- cols  input  4  keypad column lines, active-low, externally pulled up; asynchronous to clk.
- rows  output  4  keypad row drive, active-low one-hot.
- key_code  output  4  code of the confirmed key, equal to 4*row + col.
- key_valid  output  1  key_code holds an unconsumed key.
- key_ready  input  1  consumer accepts key_code this cycle.
- key_overrun  output  1  one-cycle pulse: a confirmed key was dropped.

Behaviour:
- Reset (async assert, sync release):
  - rows=4'b1110, row index 0, key_code=0, key_valid=0, key_overrun=0.
  - State SCAN; tick and debounce counters 0; col synchronizer flops 4'hF.
- Reset asserted mid-operation discards any pending key with no overrun pulse.
- Synchronizer: cols passes through 2 flops (cols_s) before any use.
- Tick generation:
  - Free-running counter 0..SCAN_DIV-1.
  - tick=1 in the cycle the counter equals SCAN_DIV-1, then the counter wraps to 0.
  - All matrix sampling happens only on tick cycles.
- State SCAN:
  - On tick with cols_s==4'hF, row index advances 0,1,2,3,0 (wrap) and rows updates the next cycle.
  - On tick with any bit of cols_s low: latch row index, latch col = lowest-index low bit, debounce count=1, go to DEBOUNCE. The row index does not advance.
- State DEBOUNCE (same row still driven):
  - On tick, if the latched col bit is low, count+1.
  - Otherwise (key bounced or released), go to SCAN and advance the row.
  - When the count reaches DEBOUNCE_SCANS, the press is confirmed and the state goes to HELD.
  - With DEBOUNCE_SCANS=1, confirmation occurs on the detecting tick: SCAN goes straight to HELD.
- Confirmation, in the cycle after the confirming tick:
  - If key_valid==0 or key_ready==1 in the confirming cycle: key_code=4*row+col, key_valid=1.
  - Else key_code and key_valid are unchanged and key_overrun pulses 1 cycle.
- State HELD (same row still driven):
  - On tick with the latched col bit high, count release samples; any low sample resets the count to 0.
  - When the release count reaches DEBOUNCE_SCANS, go to SCAN with the row advanced.
  - No repeat codes are generated while a key is held.
- Handshake:
  - key_valid falls the cycle after key_valid&&key_ready, unless a new key loads in that same cycle, in which case it stays 1 with the new code.
  - key_code is stable while key_valid=1 and the key is unaccepted.
- Multiple keys pressed:
  - Only the key in the scanned row with the lowest col index is reported.
  - Other keys are ignored until a release is confirmed.
- Ghosting: no detection is required.

Decomposition:
- Package keypad_pkg:
  - Constants NUM_ROWS=4 and NUM_COLS=4.
  - Scan-state enum {SCAN, DEBOUNCE, HELD}.
  - Function mapping (row, col) to code.
- Sub-module scan_divider(clk, rst_n, tick), parameterised by SCAN_DIV.
  - Reused by the display-refresh path.
- The synchronizer and FSM stay inline.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3):
1. Reset, no keys pressed: rows cycles 1110, 1101, 1011, 0111, 1110 with 4 clk per step; key_valid stays 0.
2. Hold row2/col1 low from t0, key_ready=1: exactly one pulse of key_valid with key_code=9. Rows freezes at 1011 until 3 release ticks after the key is released.
3. Bounce: col0 low on row0 for 2 ticks then high: no key_valid, scanning resumes at row1. A stable press afterwards gives key_code=0.
4. key_ready=0; press key 5, release, then press key 14: key_valid=1 with key_code=5 held throughout, and key_overrun pulses once on key 14's confirmation.
5. key_valid=1 (code 3); key_ready pulses in the same cycle key 12 confirms: key_valid stays 1, key_code=12, no overrun.
6. rst_n asserted low mid-DEBOUNCE and mid-HELD: outputs return immediately to their reset values. After release, a held key is re-detected and re-reported once.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad matrix constants, scan states and code helpers
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int ROW_W    = $clog2(NUM_ROWS);
  localparam int COL_W    = $clog2(NUM_COLS);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } scan_state_t;

  function automatic logic [ROW_W+COL_W-1:0] key_code_of(input logic [ROW_W-1:0] row,
                                                         input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

  // Active-low column lines: the lowest-index low bit wins when several keys share a row.
  function automatic logic [COL_W-1:0] lowest_low_col(input logic [NUM_COLS-1:0] c);
    logic [COL_W-1:0] idx;
    idx = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (!c[i]) idx = COL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_divider.sv
// rtl/scan_divider.sv - free-running divider producing a one-cycle scan tick every SCAN_DIV clocks
module scan_divider #(
  parameter int SCAN_DIV = 25000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner with debounce and valid/ready key delivery
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_COLS-1:0]      cols,
  output logic [NUM_ROWS-1:0]      rows,
  output logic [ROW_W+COL_W-1:0]   key_code,
  output logic                     key_valid,
  input  logic                     key_ready,
  output logic                     key_overrun
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_SCANS);

  logic                   tick;
  logic [NUM_COLS-1:0]    cols_meta;
  logic [NUM_COLS-1:0]    cols_s;

  scan_state_t            state, state_nxt;
  logic [ROW_W-1:0]       row_idx, row_nxt;
  logic [COL_W-1:0]       col_lat, col_nxt;
  logic [CNT_W-1:0]       deb_cnt, cnt_nxt;
  logic                   confirm;
  logic                   col_low;
  logic [ROW_W+COL_W-1:0] confirm_code;

  scan_divider #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // cols is asynchronous to clk; only cols_s is ever looked at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cols_meta <= '1;
      cols_s    <= '1;
    end else begin
      cols_meta <= cols;
      cols_s    <= cols_meta;
    end
  end

  assign rows    = ~(NUM_ROWS'(1) << row_idx);
  assign col_low = !cols_s[col_lat];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SCAN;
      row_idx <= '0;
      col_lat <= '0;
      deb_cnt <= '0;
    end else begin
      state   <= state_nxt;
      row_idx <= row_nxt;
      col_lat <= col_nxt;
      deb_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    row_nxt   = row_idx;
    col_nxt   = col_lat;
    cnt_nxt   = deb_cnt;
    confirm   = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (cols_s == '1) begin
            row_nxt = row_idx + 1'b1;
          end else begin
            col_nxt = lowest_low_col(cols_s);
            if (DEBOUNCE_SCANS == 1) begin
              state_nxt = HELD;
              cnt_nxt   = '0;
              confirm   = 1'b1;
            end else begin
              state_nxt = DEBOUNCE;
              cnt_nxt   = CNT_W'(1);
            end
          end
        end
        DEBOUNCE: begin
          if (col_low) begin
            if (deb_cnt + 1'b1 == DEB_LAST) begin
              state_nxt = HELD;
              cnt_nxt   = '0;
              confirm   = 1'b1;
            end else begin
              cnt_nxt = deb_cnt + 1'b1;
            end
          end else begin
            state_nxt = SCAN;
            row_nxt   = row_idx + 1'b1;
            cnt_nxt   = '0;
          end
        end
        HELD: begin
          // Release must be seen on consecutive ticks; any low sample restarts the count.
          if (!col_low) begin
            if (deb_cnt + 1'b1 == DEB_LAST) begin
              state_nxt = SCAN;
              row_nxt   = row_idx + 1'b1;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = deb_cnt + 1'b1;
            end
          end else begin
            cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt = SCAN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign confirm_code = key_code_of(row_idx, col_nxt);

  // A confirmed key loads only if the slot is free or being emptied this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_overrun <= 1'b0;
    end else begin
      key_overrun <= 1'b0;
      if (confirm) begin
        if (!key_valid || key_ready) begin
          key_code  <= confirm_code;
          key_valid <= 1'b1;
        end else begin
          key_overrun <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule
